// File: rtl/tetris_key_ctrl.sv
// rtl/tetris_key_ctrl.sv - sync, debounce, edge-detect and auto-repeat for three Tetris push-buttons
module tetris_key_ctrl #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BtnLeft,
    input  logic       BtnRight,
    input  logic       BtnChange,
    output logic       KeyLeft,
    output logic       KeyRight,
    output logic       KeyChange,
    output logic [2:0] KeyHeld
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // Bit order everywhere: [0] Left, [1] Right, [2] Change; 1 means pressed.
    logic [2:0] raw_pressed;
    logic [2:0] db_w;
    logic [2:0] rise_w;
    logic [1:0] pulse_lr_w;

    assign raw_pressed = (ACTIVE_LOW != 0) ? ~{BtnChange, BtnRight, BtnLeft}
                                           :  {BtnChange, BtnRight, BtnLeft};

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             db_q, db_d;
        logic             db_prev_q, db_prev_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Synchroniser chain plus debounce: db flips only after DEBOUNCE_CYCLES of steady disagreement.
        always_comb begin
            sync1_d   = raw_pressed[g];
            sync2_d   = sync1_q;
            db_d      = db_q;
            cnt_d     = '0;
            db_prev_d = db_q;
            if (sync2_q != db_q) begin
                if (cnt_q == DB_MAX) begin
                    db_d  = ~db_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Input-path state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                db_q      <= 1'b0;
                db_prev_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                db_q      <= db_d;
                db_prev_q <= db_prev_d;
                cnt_q     <= cnt_d;
            end
        end

        assign db_w[g]   = db_q;
        assign rise_w[g] = db_q & ~db_prev_q;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dir
        localparam int OPP = 1 - g;

        state_t           st_q, st_d;
        logic [CNT_W-1:0] rep_q, rep_d;
        logic             pulse_q, pulse_d;

        // Direction FSM: initial pulse, delayed auto-repeat, and lockout while the opposite key is down.
        always_comb begin
            st_d    = st_q;
            rep_d   = rep_q;
            pulse_d = 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (rise_w[g]) begin
                        rep_d = '0;
                        if (db_w[OPP]) begin
                            st_d = ST_LOCK;
                        end else begin
                            st_d    = ST_DELAY;
                            pulse_d = 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!db_w[g]) begin
                        st_d  = ST_IDLE;
                        rep_d = '0;
                    end else if (db_w[OPP]) begin
                        st_d  = ST_LOCK;
                        rep_d = '0;
                    end else if (rep_q == RD_MAX) begin
                        st_d    = ST_REPEAT;
                        pulse_d = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!db_w[g]) begin
                        st_d  = ST_IDLE;
                        rep_d = '0;
                    end else if (db_w[OPP]) begin
                        st_d  = ST_LOCK;
                        rep_d = '0;
                    end else if (rep_q == RP_MAX) begin
                        pulse_d = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                ST_LOCK: begin
                    // Only releasing this key re-arms it; the opposite key's release is ignored.
                    if (!db_w[g]) begin
                        st_d = ST_IDLE;
                    end
                end
                default: begin
                    st_d  = ST_IDLE;
                    rep_d = '0;
                end
            endcase
        end

        // Direction FSM state, repeat counter and registered pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q    <= ST_IDLE;
                rep_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                st_q    <= st_d;
                rep_q   <= rep_d;
                pulse_q <= pulse_d;
            end
        end

        assign pulse_lr_w[g] = pulse_q;
    end

    logic change_q, change_d;

    // Rotate fires once per debounced press, never locked, never repeated.
    always_comb begin
        change_d = rise_w[2];
    end

    // Registered rotate pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            change_q <= 1'b0;
        end else begin
            change_q <= change_d;
        end
    end

    assign KeyLeft   = pulse_lr_w[0];
    assign KeyRight  = pulse_lr_w[1];
    assign KeyChange = change_q;
    assign KeyHeld   = db_w;

endmodule

// File: tb/tb_tetris_key_ctrl.sv
// tb/tb_tetris_key_ctrl.sv - directed self-checking bench for tetris_key_ctrl
module tb_tetris_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BtnLeft = 1'b1;
    logic       BtnRight = 1'b1;
    logic       BtnChange = 1'b1;
    logic       KeyLeft;
    logic       KeyRight;
    logic       KeyChange;
    logic [2:0] KeyHeld;

    int vectors = 0;
    int errors  = 0;

    tetris_key_ctrl #(
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .BtnLeft  (BtnLeft),
        .BtnRight (BtnRight),
        .BtnChange(BtnChange),
        .KeyLeft  (KeyLeft),
        .KeyRight (KeyRight),
        .KeyChange(KeyChange),
        .KeyHeld  (KeyHeld)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {KeyChange, KeyRight, KeyLeft, KeyHeld[2:0]}
    function automatic logic [5:0] obs();
        return {KeyChange, KeyRight, KeyLeft, KeyHeld};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        BtnLeft   = 1'b1;
        BtnRight  = 1'b1;
        BtnChange = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        got = obs();
        vectors++;
        if (got !== 6'b000000) begin
            errors++;
            $display("FAIL reset_async: got %b want 000000", got);
        end
        tick();
        tick();
        got = obs();
        vectors++;
        if (got !== 6'b000000) begin
            errors++;
            $display("FAIL reset_held: got %b want 000000", got);
        end
        rst = 1'b0;
        tick();
        got = obs();
        vectors++;
        if (got !== 6'b000000) begin
            errors++;
            $display("FAIL reset_release: got %b want 000000", got);
        end
    endtask

    task automatic test_tap();
        logic [5:0] exp;
        logic [5:0] got;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            BtnChange = (c < 20) ? 1'b0 : 1'b1;
            tick();
            exp = {(c + 1 == 7), 1'b0, 1'b0, (c + 1 >= 6 && c + 1 <= 25), 2'b00};
            got = obs();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL tap cycle %0d: got %b want %b", c + 1, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] got;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            BtnLeft = (c < 12) ? (((c / 2) % 2) == 0 ? 1'b0 : 1'b1) : 1'b1;
            tick();
            got = obs();
            vectors++;
            if (got !== 6'b000000) begin
                errors++;
                $display("FAIL bounce cycle %0d: got %b want 000000", c + 1, got);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [5:0] exp;
        logic [5:0] got;
        int         k;
        logic       pr;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            BtnRight = (c < 40) ? 1'b0 : 1'b1;
            tick();
            k  = c + 1;
            pr = (k == 7) || (k >= 17 && k <= 44 && ((k - 17) % 3) == 0);
            exp = {1'b0, pr, 1'b0, 1'b0, (k >= 6 && k <= 45), 1'b0};
            got = obs();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_repeat cycle %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_lockout();
        logic [5:0] exp;
        logic [5:0] got;
        int         k;
        logic       pl;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            BtnLeft  = (c < 50 || c >= 60) ? 1'b0 : 1'b1;
            BtnRight = (c >= 10 && c < 30) ? 1'b0 : 1'b1;
            tick();
            k  = c + 1;
            pl = (k == 7) || (k == 67) || (k == 77) || (k == 80);
            exp = {1'b0, 1'b0, pl, 1'b0, (k >= 16 && k <= 35),
                   ((k >= 6 && k <= 55) || k >= 66)};
            got = obs();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lockout cycle %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_both_pressed();
        logic [5:0] exp;
        logic [5:0] got;
        int         k;
        logic       hlr;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            BtnLeft   = (c < 30) ? 1'b0 : 1'b1;
            BtnRight  = (c < 30) ? 1'b0 : 1'b1;
            BtnChange = (c >= 10 && c < 20) ? 1'b0 : 1'b1;
            tick();
            k   = c + 1;
            hlr = (k >= 6 && k <= 35);
            exp = {(k == 17), 1'b0, 1'b0, (k >= 16 && k <= 25), hlr, hlr};
            got = obs();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL both_pressed cycle %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [5:0] exp;
        logic [5:0] got;
        int         k;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            BtnLeft = 1'b0;
            rst = (c == 12 || c == 13) ? 1'b1 : 1'b0;
            if (c == 12) begin
                #1;
                got = obs();
                vectors++;
                if (got !== 6'b000000) begin
                    errors++;
                    $display("FAIL reset_mid_hold_async: got %b want 000000", got);
                end
            end
            tick();
            k = c + 1;
            exp = {1'b0, 1'b0, (k == 7 || k == 21), 2'b00,
                   ((k >= 6 && k <= 12) || k >= 20)};
            got = obs();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_hold cycle %0d: got %b want %b", k, got, exp);
            end
        end
        rst = 1'b0;
        BtnLeft = 1'b1;
    endtask

    initial begin
        test_reset();
        test_tap();
        test_bounce();
        test_hold_repeat();
        test_lockout();
        test_both_pressed();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
